// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and frame constants for the PS/2 receive path.
//   ps2_rx_state_t : deframer states (IDLE, RECV, CHECK)
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_START      : level of the start bit
//   PS2_STOP       : level of the stop bit
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      CHECK
   } ps2_rx_state_t;

   localparam int   PS2_FRAME_BITS = 11;
   localparam logic PS2_START      = 1'b0;
   localparam logic PS2_STOP       = 1'b1;

   // Odd parity holds when data bits plus parity bit contain an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] byte_i, input logic parity_i);
      return ^{byte_i, parity_i};
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo
//   Byte FIFO between the PS/2 deframer and the downstream scan-code decoder.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (pointers and slots cleared)
//   push_i       write push_data_i at the tail; refused while full unless a pop
//                takes effect in the same cycle
//   push_data_i  byte to write
//   pop_i        advance the head; ignored while empty
//   full_o       all DEPTH slots occupied
//   empty_o      no slot occupied
//   head_o       byte in the head slot (combinational read)
module ps2_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output logic [7:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
   assign do_push = push_i && (!full_o || do_pop);

   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver. Synchronises ps2_clk/ps2_data, deframes
//   11-bit frames (start 0, 8 data LSB first, odd parity, stop 1) and buffers
//   the received bytes for the scan-code decoder.
//   Build option: define PS2_RX_PARITY_CHECK_EN to reject frames with bad
//   odd parity; otherwise the parity bit is ignored.
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   ps2_clk     raw PS/2 clock pin
//   ps2_data    raw PS/2 data pin
//   nextdata_n  active-low pop request, one byte per cycle while low and ready
//   data        FIFO head byte, valid while ready=1
//   ready       FIFO non-empty
//   overflow    sticky: a good frame arrived while the FIFO was full
//   frame_err   sticky: a frame was rejected (bad stop, or bad parity if enabled)
//
// state | meaning
// IDLE  | waiting for a falling edge with a start bit on the data line
// RECV  | collecting frame bits; abandons the frame after TIMEOUT_CYCLES of silence
// CHECK | one cycle: validate the complete frame and push the byte if good
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int               TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       LAST_BIT_CNT = 4'(PS2_FRAME_BITS - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   ps2_rx_state_t          state_q;
   logic [3:0]             bitcnt_q;
   logic [10:0]            shift_q;
   logic [TO_W-1:0]        timeout_q;
   logic                   frame_err_q;
   logic                   overflow_q;

   logic                   fall;
   logic                   din;
   logic                   frame_ok_d;
   logic                   parity_ok_d;
   logic                   push_d;
   logic                   pop_req;
   logic                   fifo_full;
   logic                   fifo_empty;

   // Sync flops idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign fall = !clk_sync_q[SYNC_STAGES-2] && clk_sync_q[SYNC_STAGES-1];
   assign din  = data_sync_q[SYNC_STAGES-1];

   // After 11 shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
`ifdef PS2_RX_PARITY_CHECK_EN
   assign parity_ok_d = ps2_odd_parity_ok(shift_q[8:1], shift_q[9]);
`else
   logic parity_unused;
   assign parity_unused = shift_q[9];
   assign parity_ok_d   = 1'b1;
`endif

   assign frame_ok_d = (shift_q[0] == PS2_START) && (shift_q[10] == PS2_STOP) && parity_ok_d;
   assign push_d     = (state_q == CHECK) && frame_ok_d;
   assign pop_req    = !nextdata_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '1;
         timeout_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         if (fall) begin
            shift_q <= {din, shift_q[10:1]};
         end
         case (state_q)
            IDLE: begin
               timeout_q <= '0;
               if (fall && (din == PS2_START)) begin
                  state_q  <= RECV;
                  bitcnt_q <= 4'd1;
               end
            end
            RECV: begin
               if (fall) begin
                  timeout_q <= '0;
                  bitcnt_q  <= bitcnt_q + 4'd1;
                  if (bitcnt_q == LAST_BIT_CNT) begin
                     state_q <= CHECK;
                  end
               end else if (timeout_q == TO_LAST) begin
                  // Device went silent mid-frame: drop it quietly.
                  state_q   <= IDLE;
                  bitcnt_q  <= '0;
                  timeout_q <= '0;
               end else begin
                  timeout_q <= timeout_q + 1'b1;
               end
            end
            CHECK: begin
               state_q  <= IDLE;
               bitcnt_q <= '0;
               if (!frame_ok_d) begin
                  frame_err_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               bitcnt_q <= '0;
            end
         endcase
      end
   end

   // When full the FIFO is non-empty, so any pop request frees a slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (push_d && fifo_full && !pop_req) begin
         overflow_q <= 1'b1;
      end
   end

   ps2_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (reset),
      .push_i      (push_d),
      .push_data_i (shift_q[8:1]),
      .pop_i       (pop_req),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (data)
   );

   assign ready     = !fifo_empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Directed bench for ps2_rx_fifo. The PS/2 clock runs at 100 system clocks
//   per bit and the timeout is shortened to 1500 cycles so the whole run stays
//   short; the ratios between bit period, sync delay and timeout are preserved.
module tb_ps2_rx_fifo;

   localparam int PS2_HALF = 50;
   localparam int TO       = 1500;

   logic       clk;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   ps2_rx_fifo #(
      .FIFO_DEPTH     (8),
      .SYNC_STAGES    (3),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip_par,
                                              input logic stop);
      return {stop, (~^b) ^ flip_par, b, 1'b0};
   endfunction

   // Data changes mid-way through the high phase, then the clock falls.
   task automatic drive_bit(input logic b);
      repeat (PS2_HALF / 2) @(negedge clk);
      ps2_data = b;
      repeat (PS2_HALF - PS2_HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (PS2_HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) drive_bit(f[i]);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(make_frame(b, 1'b0, 1'b1), 11);
   endtask

   task automatic pop_one();
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ready, overflow, frame_err} !== 3'b000 || data !== 8'h00) begin
         errors++;
         $display("FAIL reset_in got rdy=%0b ovf=%0b ferr=%0b data=%h exp 0 0 0 00",
                  ready, overflow, frame_err, data);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({ready, overflow, frame_err} !== 3'b000 || data !== 8'h00) begin
         errors++;
         $display("FAIL reset_out got rdy=%0b ovf=%0b ferr=%0b data=%h exp 0 0 0 00",
                  ready, overflow, frame_err, data);
      end
   endtask

   task automatic test_single_latency();
      logic [10:0] f;
      f = make_frame(8'h1C, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive_bit(f[i]);
      repeat (PS2_HALF / 2) @(negedge clk);
      ps2_data = f[10];
      repeat (PS2_HALF - PS2_HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      // 2 sync cycles to see the edge, 1 into CHECK, 1 to write the byte.
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL lat_early got ready=%0b exp 0", ready);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || data !== 8'h1C || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL lat_byte got rdy=%0b data=%h ferr=%0b exp 1 1c 0", ready, data, frame_err);
      end
      repeat (PS2_HALF - 4) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || data !== 8'h1C) begin
         errors++;
         $display("FAIL hold_byte got rdy=%0b data=%h exp 1 1c", ready, data);
      end
   endtask

   task automatic test_order();
      logic [7:0] exp_b [3];
      exp_b = '{8'hE0, 8'hF0, 8'h75};
      do_reset();
      for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ready !== 1'b1 || data !== exp_b[i]) begin
            errors++;
            $display("FAIL order_%0d got rdy=%0b data=%h exp 1 %h", i, ready, data, exp_b[i]);
         end
         pop_one();
      end
      checks++;
      if (ready !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL order_empty got rdy=%0b ferr=%0b exp 0 0", ready, frame_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      checks++;
      if (overflow !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL ovf_at_full got ovf=%0b rdy=%0b exp 0 1", overflow, ready);
      end
      send_byte(8'h09);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got ovf=%0b exp 1", overflow);
      end
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (ready !== 1'b1 || data !== 8'(i)) begin
            errors++;
            $display("FAIL ovf_pop_%0d got rdy=%0b data=%h exp 1 %h", i, ready, data, 8'(i));
         end
         pop_one();
      end
      checks++;
      if (ready !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain got rdy=%0b ovf=%0b exp 0 1", ready, overflow);
      end
   endtask

   task automatic test_timeout();
      logic [10:0] f;
      do_reset();
      // A pause shorter than the timeout must not break the frame.
      f = make_frame(8'h33, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive_bit(f[i]);
      repeat (TO - 300) @(negedge clk);
      for (int i = 5; i < 11; i++) drive_bit(f[i]);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || data !== 8'h33) begin
         errors++;
         $display("FAIL short_pause got rdy=%0b data=%h exp 1 33", ready, data);
      end
      pop_one();
      // Partial frame, then silence past the timeout, then a good frame.
      send_bits(make_frame(8'hFF, 1'b0, 1'b1), 5);
      repeat (TO + 100) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL to_partial got ready=%0b exp 0", ready);
      end
      send_byte(8'h29);
      checks++;
      if (ready !== 1'b1 || data !== 8'h29 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL to_byte got rdy=%0b data=%h ferr=%0b exp 1 29 0", ready, data, frame_err);
      end
      pop_one();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL to_only_one got ready=%0b exp 0", ready);
      end
   endtask

   task automatic test_errors();
      do_reset();
      send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
`ifdef PS2_RX_PARITY_CHECK_EN
      checks++;
      if (ready !== 1'b0 || frame_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_drop got rdy=%0b ferr=%0b exp 0 1", ready, frame_err);
      end
`else
      checks++;
      if (ready !== 1'b1 || data !== 8'h1C || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_ign got rdy=%0b data=%h ferr=%0b exp 1 1c 0", ready, data, frame_err);
      end
      pop_one();
`endif
      send_bits(make_frame(8'h3A, 1'b0, 1'b0), 11);
      checks++;
      if (ready !== 1'b0 || frame_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_stop got rdy=%0b ferr=%0b exp 0 1", ready, frame_err);
      end
   endtask

   task automatic test_reset_midframe();
      logic [10:0] f;
      do_reset();
      send_byte(8'h11);
      send_bits(make_frame(8'hC3, 1'b0, 1'b1), 6);
      repeat (PS2_HALF / 2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || data !== 8'h00 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got rdy=%0b data=%h ferr=%0b exp 0 00 0", ready, data, frame_err);
      end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      f = make_frame(8'h5A, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive_bit(f[i]);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_wait got ready=%0b exp 0", ready);
      end
      drive_bit(f[10]);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || data !== 8'h5A || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_byte got rdy=%0b data=%h ferr=%0b exp 1 5a 0", ready, data, frame_err);
      end
   endtask

   initial begin
      reset      = 1'b1;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      nextdata_n = 1'b1;
      test_reset();
      test_single_latency();
      test_order();
      test_overflow();
      test_timeout();
      test_errors();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
